// File: rtl/ysyx_22041752_rf_wport_arb_if.sv
// Bundle of the register-file write-port arbiter's WS, LLU, regfile and ID signals.
interface ysyx_22041752_rf_wport_arb_if #(
  parameter int unsigned RF_ADDR_WD = 5,
  parameter int unsigned RF_DATA_WD = 64
);
  logic                  ws_we;
  logic [RF_ADDR_WD-1:0] ws_waddr;
  logic [RF_DATA_WD-1:0] ws_wdata;
  logic                  ws_hold;
  logic                  llu_issue_valid;
  logic [RF_ADDR_WD-1:0] llu_issue_rd;
  logic                  llu_res_valid;
  logic                  llu_res_ready;
  logic [RF_ADDR_WD-1:0] llu_res_rd;
  logic [RF_DATA_WD-1:0] llu_res_data;
  logic                  rf_we;
  logic [RF_ADDR_WD-1:0] rf_waddr;
  logic [RF_DATA_WD-1:0] rf_wdata;
  logic [RF_ADDR_WD-1:0] id_rs1;
  logic [RF_ADDR_WD-1:0] id_rs2;
  logic [RF_ADDR_WD-1:0] id_rd;
  logic                  id_hazard;

  // Pipeline side: drives requests, observes grants and hazard.
  modport master (
    output ws_we, ws_waddr, ws_wdata,
    output llu_issue_valid, llu_issue_rd,
    output llu_res_valid, llu_res_rd, llu_res_data,
    output id_rs1, id_rs2, id_rd,
    input  ws_hold, llu_res_ready, rf_we, rf_waddr, rf_wdata, id_hazard
  );

  // Arbiter side.
  modport slave (
    input  ws_we, ws_waddr, ws_wdata,
    input  llu_issue_valid, llu_issue_rd,
    input  llu_res_valid, llu_res_rd, llu_res_data,
    input  id_rs1, id_rs2, id_rd,
    output ws_hold, llu_res_ready, rf_we, rf_waddr, rf_wdata, id_hazard
  );
endinterface

// File: rtl/ysyx_22041752_rf_wport_arb.sv
// Register-file write-port arbiter between writeback (WS) and the long-latency unit (LLU).
// Keeps a 1-entry LLU result buffer, WS-priority arbitration with anti-starvation,
// and a busy scoreboard of pending LLU destinations for ID hazard detection.
module ysyx_22041752_rf_wport_arb #(
  parameter int unsigned RF_ADDR_WD = 5,
  parameter int unsigned RF_DATA_WD = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic clk,
  input logic reset,
  ysyx_22041752_rf_wport_arb_if.slave bus
);
  localparam int unsigned NUM_REGS = 1 << RF_ADDR_WD;
  localparam int unsigned CNT_WD   = $clog2(STARVE_MAX + 1);

  logic                  buf_valid;
  logic [RF_ADDR_WD-1:0] buf_rd;
  logic [RF_DATA_WD-1:0] buf_data;
  logic [CNT_WD-1:0]     starve_cnt;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_nxt;

  logic force_c;
  logic llu_grant_c;
  logic ws_grant_c;
  logic accept_c;

  assign force_c  = buf_valid && (starve_cnt == CNT_WD'(STARVE_MAX));
  assign accept_c = bus.llu_res_valid && !buf_valid;

  // Port grant: forced LLU drain first, then WS, then buffered LLU result; nothing writes in reset.
  always_comb begin
    llu_grant_c = 1'b0;
    ws_grant_c  = 1'b0;
    if (!reset) begin
      if (force_c)          llu_grant_c = 1'b1;
      else if (bus.ws_we)   ws_grant_c  = 1'b1;
      else if (buf_valid)   llu_grant_c = 1'b1;
    end
  end

  assign bus.ws_hold       = !reset && force_c && bus.ws_we;
  assign bus.llu_res_ready = !buf_valid;
  assign bus.rf_we         = llu_grant_c || (ws_grant_c && (bus.ws_waddr != '0));
  assign bus.rf_waddr      = llu_grant_c ? buf_rd   : bus.ws_waddr;
  assign bus.rf_wdata      = llu_grant_c ? buf_data : bus.ws_wdata;
  assign bus.id_hazard     = busy[bus.id_rs1] | busy[bus.id_rs2] | busy[bus.id_rd];

  // Scoreboard update: write grant clears, issue sets afterwards so a same-reg set wins.
  always_comb begin
    busy_nxt = busy;
    if (llu_grant_c) busy_nxt[buf_rd] = 1'b0;
    if (bus.llu_issue_valid && (bus.llu_issue_rd != '0)) busy_nxt[bus.llu_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Buffer, starvation counter and scoreboard state.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid  <= 1'b0;
      buf_rd     <= '0;
      buf_data   <= '0;
      starve_cnt <= '0;
      busy       <= '0;
    end else begin
      busy <= busy_nxt;
      if (llu_grant_c) begin
        buf_valid <= 1'b0;
      end else if (accept_c && (bus.llu_res_rd != '0)) begin
        buf_valid <= 1'b1;
        buf_rd    <= bus.llu_res_rd;
        buf_data  <= bus.llu_res_data;
      end
      if (!buf_valid || llu_grant_c) begin
        starve_cnt <= '0;
      end else if (ws_grant_c && (starve_cnt != CNT_WD'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + CNT_WD'(1);
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22041752_rf_wport_arb.sv
// Self-checking bench for the register-file write-port arbiter.
module tb_ysyx_22041752_rf_wport_arb;
  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 64;
  localparam int unsigned SMX = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ysyx_22041752_rf_wport_arb_if #(.RF_ADDR_WD(AW), .RF_DATA_WD(DW)) bus ();

  ysyx_22041752_rf_wport_arb #(.RF_ADDR_WD(AW), .RF_DATA_WD(DW), .STARVE_MAX(SMX)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending LLU result, how many times it lost to WS, set of busy regs.
  bit          m_pend;
  bit [AW-1:0] m_pend_rd;
  bit [DW-1:0] m_pend_data;
  int          m_losses;
  bit          m_busy[32];
  bit          m_llu_win;
  bit          m_ws_win;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // At the negative edge: derive expected outputs from the model and compare.
  task automatic tick_check();
    bit e_we, e_hold, e_haz;
    @(negedge clk);
    m_llu_win = 1'b0;
    m_ws_win  = 1'b0;
    if (!reset) begin
      if (m_pend && m_losses >= int'(SMX)) m_llu_win = 1'b1;
      else if (bus.ws_we)                  m_ws_win  = 1'b1;
      else if (m_pend)                     m_llu_win = 1'b1;
    end
    e_hold = !reset && m_pend && (m_losses >= int'(SMX)) && bus.ws_we;
    e_we   = m_llu_win || (m_ws_win && bus.ws_waddr != 0);
    e_haz  = (bus.id_rs1 != 0 && m_busy[bus.id_rs1]) ||
             (bus.id_rs2 != 0 && m_busy[bus.id_rs2]) ||
             (bus.id_rd  != 0 && m_busy[bus.id_rd]);
    chk("rf_we",         64'(bus.rf_we),         64'(e_we));
    chk("ws_hold",       64'(bus.ws_hold),       64'(e_hold));
    chk("llu_res_ready", 64'(bus.llu_res_ready), 64'(!m_pend));
    chk("id_hazard",     64'(bus.id_hazard),     64'(e_haz));
    if (m_llu_win) begin
      chk("rf_waddr_llu", 64'(bus.rf_waddr), 64'(m_pend_rd));
      chk("rf_wdata_llu", bus.rf_wdata,      m_pend_data);
    end else if (e_we) begin
      chk("rf_waddr_ws", 64'(bus.rf_waddr), 64'(bus.ws_waddr));
      chk("rf_wdata_ws", bus.rf_wdata,      bus.ws_wdata);
    end
  endtask

  // Across the positive edge: advance the model with this cycle's inputs.
  task automatic advance();
    bit was_pend;
    @(posedge clk);
    was_pend = m_pend;
    if (reset) begin
      m_pend   = 1'b0;
      m_losses = 0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else begin
      if (m_llu_win) begin
        m_pend = 1'b0;
        m_busy[m_pend_rd] = 1'b0;
        m_losses = 0;
      end else if (m_ws_win && was_pend && m_losses < int'(SMX)) begin
        m_losses++;
      end
      if (bus.llu_res_valid && !was_pend && bus.llu_res_rd != 0) begin
        m_pend      = 1'b1;
        m_pend_rd   = bus.llu_res_rd;
        m_pend_data = bus.llu_res_data;
        m_losses    = 0;
      end
      if (bus.llu_issue_valid && bus.llu_issue_rd != 0) m_busy[bus.llu_issue_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic cyc();
    tick_check();
    advance();
  endtask

  task automatic idle_inputs();
    bus.ws_we = 1'b0; bus.ws_waddr = '0; bus.ws_wdata = '0;
    bus.llu_issue_valid = 1'b0; bus.llu_issue_rd = '0;
    bus.llu_res_valid = 1'b0; bus.llu_res_rd = '0; bus.llu_res_data = '0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
  endtask

  initial begin
    m_pend = 1'b0; m_pend_rd = '0; m_pend_data = '0; m_losses = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    idle_inputs();

    // 1: reset then idle
    reset = 1'b1;
    #1;
    advance();
    advance();
    reset = 1'b0;
    tick_check();
    chk("t1_rf_we", 64'(bus.rf_we), 64'd0);
    chk("t1_ready", 64'(bus.llu_res_ready), 64'd1);
    chk("t1_hold", 64'(bus.ws_hold), 64'd0);
    chk("t1_haz", 64'(bus.id_hazard), 64'd0);
    advance();

    // 2: issue rd=5, hazard, result written the cycle after acceptance
    bus.llu_issue_valid = 1'b1; bus.llu_issue_rd = 5'd5;
    cyc();
    bus.llu_issue_valid = 1'b0; bus.id_rs1 = 5'd5;
    tick_check();
    chk("t2_haz", 64'(bus.id_hazard), 64'd1);
    advance();
    bus.llu_res_valid = 1'b1; bus.llu_res_rd = 5'd5; bus.llu_res_data = 64'h1234;
    cyc();
    bus.llu_res_valid = 1'b0;
    tick_check();
    chk("t2_we", 64'(bus.rf_we), 64'd1);
    chk("t2_waddr", 64'(bus.rf_waddr), 64'd5);
    chk("t2_wdata", bus.rf_wdata, 64'h1234);
    advance();
    tick_check();
    chk("t2_haz_clr", 64'(bus.id_hazard), 64'd0);
    advance();
    idle_inputs();

    // 3: starvation: WS wins four times, then forced LLU write with WS held
    bus.llu_issue_valid = 1'b1; bus.llu_issue_rd = 5'd9;
    cyc();
    bus.llu_issue_valid = 1'b0;
    bus.llu_res_valid = 1'b1; bus.llu_res_rd = 5'd9; bus.llu_res_data = 64'hABCD;
    bus.ws_we = 1'b1; bus.ws_waddr = 5'd10; bus.ws_wdata = 64'h100;
    cyc();
    bus.llu_res_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.ws_waddr = 5'(11 + k); bus.ws_wdata = 64'(200 + k);
      tick_check();
      chk("t3_ws_addr", 64'(bus.rf_waddr), 64'(11 + k));
      chk("t3_no_hold", 64'(bus.ws_hold), 64'd0);
      advance();
    end
    bus.ws_waddr = 5'd20; bus.ws_wdata = 64'h300;
    tick_check();
    chk("t3_force_addr", 64'(bus.rf_waddr), 64'd9);
    chk("t3_force_hold", 64'(bus.ws_hold), 64'd1);
    advance();
    tick_check();
    chk("t3_ws_after", 64'(bus.rf_waddr), 64'd20);
    chk("t3_hold_after", 64'(bus.ws_hold), 64'd0);
    advance();
    idle_inputs();

    // 4: result to x0: accepted, never written
    bus.llu_res_valid = 1'b1; bus.llu_res_rd = 5'd0; bus.llu_res_data = 64'hDEAD;
    cyc();
    bus.llu_res_valid = 1'b0;
    tick_check();
    chk("t4_we", 64'(bus.rf_we), 64'd0);
    chk("t4_ready", 64'(bus.llu_res_ready), 64'd1);
    advance();

    // 5: reissue rd=7 on the cycle its old result writes; ws_we to x0 is dropped
    bus.llu_issue_valid = 1'b1; bus.llu_issue_rd = 5'd7;
    cyc();
    bus.llu_issue_valid = 1'b0;
    bus.llu_res_valid = 1'b1; bus.llu_res_rd = 5'd7; bus.llu_res_data = 64'h77;
    cyc();
    bus.llu_res_valid = 1'b0;
    bus.llu_issue_valid = 1'b1; bus.llu_issue_rd = 5'd7;
    tick_check();
    chk("t5_llu_we", 64'(bus.rf_we), 64'd1);
    advance();
    bus.llu_issue_valid = 1'b0; bus.id_rs2 = 5'd7;
    bus.ws_we = 1'b1; bus.ws_waddr = 5'd0; bus.ws_wdata = 64'h55;
    tick_check();
    chk("t5_busy7", 64'(bus.id_hazard), 64'd1);
    chk("t5_x0_we", 64'(bus.rf_we), 64'd0);
    chk("t5_x0_hold", 64'(bus.ws_hold), 64'd0);
    advance();
    idle_inputs();

    // 6: reset while a result is buffered and rd=3 is busy
    bus.llu_issue_valid = 1'b1; bus.llu_issue_rd = 5'd3;
    cyc();
    bus.llu_issue_valid = 1'b0;
    bus.llu_res_valid = 1'b1; bus.llu_res_rd = 5'd3; bus.llu_res_data = 64'h33;
    bus.ws_we = 1'b1; bus.ws_waddr = 5'd12;
    cyc();
    bus.llu_res_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    idle_inputs();
    bus.id_rs1 = 5'd3;
    tick_check();
    chk("t6_we", 64'(bus.rf_we), 64'd0);
    chk("t6_ready", 64'(bus.llu_res_ready), 64'd1);
    chk("t6_haz", 64'(bus.id_hazard), 64'd0);
    advance();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      bus.ws_we           = ($urandom_range(0, 9) < 6);
      bus.ws_waddr        = 5'($urandom_range(1, 31));
      bus.ws_wdata        = {32'($urandom), 32'($urandom)};
      bus.llu_issue_valid = ($urandom_range(0, 9) < 3);
      bus.llu_issue_rd    = 5'($urandom_range(0, 31));
      bus.llu_res_valid   = ($urandom_range(0, 9) < 4);
      bus.llu_res_rd      = 5'($urandom_range(0, 31));
      bus.llu_res_data    = {32'($urandom), 32'($urandom)};
      bus.id_rs1          = 5'($urandom_range(0, 31));
      bus.id_rs2          = 5'($urandom_range(0, 31));
      bus.id_rd           = 5'($urandom_range(0, 31));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
